uart_tx_port: RTL and testbench



---
 rtl/uart_tx_port_if.sv | 28 ++
 rtl/uart_tx_port.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_port.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_port_if.sv
// rtl/uart_tx_port_if.sv - CPU bus and serial pins of the UART transmitter
//
// Purpose: bundles the decoder-slot bus (data_in/data_out/address/rw/ce),
// the interrupt pulse and the tx pin into one interface.
// Modports:
//   master - CPU/decoder side: drives data_in, address, rw, ce
//   slave  - peripheral side: drives data_out, irq, tx
interface uart_tx_port_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic [3:0]            address;
  logic                  rw;
  logic                  ce;
  logic                  irq;
  logic                  tx;

  modport master (
    output data_in, address, rw, ce,
    input  data_out, irq, tx
  );

  modport slave (
    input  data_in, address, rw, ce,
    output data_out, irq, tx
  );
endinterface

// File: rtl/uart_tx_port.sv
// rtl/uart_tx_port.sv - memory-mapped 8N1 UART transmitter with TX FIFO
//
// Purpose: CPU pushes bytes into a FIFO; an FSM serialises them LSB first
// with a programmable bit period of DIV+1 cycles and optionally pulses irq
// once the FIFO and shifter have drained.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - uart_tx_port_if.slave: data_in, data_out (combinational from
//          address), address, rw, ce, irq (one-cycle pulse), tx (idle high)
// Registers: 0x0 TX_DATA (W), 0x1 STATUS (R, write clears overflow),
//            0x2 DIV [15:0], 0x3 IRQ_EN [0].
module uart_tx_port #(
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 216
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_port_if.slave  bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_next;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [7:0]      shift_q;
  logic [2:0]      bit_cnt;
  logic [15:0]     baud;
  logic [15:0]     div_q;
  logic            irq_en_q;
  logic            ovf_q;
  logic            tx_q, tx_next;
  logic            irq_q, irq_next;
  logic            load, reload, dec, shift_en;

  logic empty, full, wr_en, push_req, push;
  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign wr_en    = bus.ce && bus.rw;
  assign push_req = wr_en && (bus.address == 4'h0);
  // Fullness is judged before this cycle's pop, so a pop never rescues a push.
  assign push     = push_req && !full;

  always_comb begin
    state_next = state;
    tx_next    = tx_q;
    load       = 1'b0;
    reload     = 1'b0;
    dec        = 1'b0;
    shift_en   = 1'b0;
    irq_next   = 1'b0;
    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (!empty) begin
          load       = 1'b1;
          state_next = START;
          tx_next    = 1'b0;
        end
      end
      START: begin
        if (baud == '0) begin
          reload     = 1'b1;
          state_next = DATA;
          tx_next    = shift_q[0];
        end else begin
          dec = 1'b1;
        end
      end
      DATA: begin
        if (baud == '0) begin
          reload = 1'b1;
          if (bit_cnt == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            shift_en = 1'b1;
            // tx is registered, so present the bit that will be at [0] after the shift.
            tx_next  = shift_q[1];
          end
        end else begin
          dec = 1'b1;
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (baud == '0) begin
          state_next = IDLE;
          // A non-empty FIFO means another frame follows: stay quiet.
          irq_next   = empty && irq_en_q;
        end else begin
          dec = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FIFO storage has no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data_in[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_q     <= 1'b1;
      irq_q    <= 1'b0;
      shift_q  <= '0;
      bit_cnt  <= '0;
      baud     <= '0;
      div_q    <= 16'(DEFAULT_DIV);
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state <= state_next;
      tx_q  <= tx_next;
      irq_q <= irq_next;

      // A DIV write only lands here at the next reload.
      if (load) begin
        shift_q <= mem[rd_ptr];
        bit_cnt <= '0;
        baud    <= div_q;
      end else if (reload) begin
        baud <= div_q;
      end else if (dec) begin
        baud <= baud - 16'd1;
      end
      if (shift_en) begin
        shift_q <= {1'b0, shift_q[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (load) rd_ptr <= rd_ptr + PW'(1);
      case ({push, load})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (wr_en && bus.address == 4'h2) div_q    <= bus.data_in[15:0];
      if (wr_en && bus.address == 4'h3) irq_en_q <= bus.data_in[0];
      if (wr_en && bus.address == 4'h1) ovf_q <= 1'b0;
      else if (push_req && full)        ovf_q <= 1'b1;
    end
  end

  always_comb begin
    bus.data_out = '0;
    case (bus.address)
      4'h1: begin
        bus.data_out[0]       = empty;
        bus.data_out[1]       = full;
        bus.data_out[2]       = (state != IDLE);
        bus.data_out[3]       = ovf_q;
        bus.data_out[4 +: CW] = count;
      end
      4'h2:    bus.data_out[15:0] = div_q;
      4'h3:    bus.data_out[0]    = irq_en_q;
      default: bus.data_out = '0;
    endcase
  end

  assign bus.tx  = tx_q;
  assign bus.irq = irq_q;
endmodule

// File: tb/tb_uart_tx_port.sv
// tb/tb_uart_tx_port.sv - self-checking bench for uart_tx_port
module tb_uart_tx_port;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_port_if #(.DATA_WIDTH(32)) bus ();
  uart_tx_port #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .DEFAULT_DIV(216)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int e_last = 0;

  // Per-cycle history sampled 2 time units after each rising edge.
  logic tx_hist   [65536];
  logic irq_hist  [65536];
  logic busy_hist [65536];
  logic bv_hist   [65536];

  always @(posedge clk) begin
    int idx;
    cyc = cyc + 1;
    #2;
    idx = cyc & 16'hFFFF;
    tx_hist[idx]   = bus.tx;
    irq_hist[idx]  = bus.irq;
    busy_hist[idx] = bus.data_out[2];
    bv_hist[idx]   = (bus.address == 4'h1) && !(bus.ce && bus.rw);
  end

  logic exp_tx[$];
  logic exp_busy[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.ce = 1'b1; bus.rw = 1'b1; bus.address = a; bus.data_in = d;
    @(posedge clk);
    #1;
    e_last = cyc;
    bus.ce = 1'b0; bus.rw = 1'b0; bus.address = 4'h1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    @(negedge clk);
    bus.address = a;
    #1;
    v = bus.data_out;
    bus.address = 4'h1;
  endtask

  // Line-level picture of back-to-back 8N1 frames: each bit is d+1 cycles,
  // frames separated by exactly one idle-high cycle.
  task automatic build_wave(input int d, input logic [7:0] bytes[$]);
    exp_tx.delete();
    exp_busy.delete();
    for (int f = 0; f < bytes.size(); f++) begin
      logic [9:0] frame;
      frame = {1'b1, bytes[f], 1'b0};
      for (int b = 0; b < 10; b++)
        for (int r = 0; r <= d; r++) begin
          exp_tx.push_back(frame[b]);
          exp_busy.push_back(1'b1);
        end
      if (f != bytes.size() - 1) begin
        exp_tx.push_back(1'b1);
        exp_busy.push_back(1'b0);
      end
    end
  endtask

  // Compare the recorded line starting the cycle after push edge e.
  task automatic check_window(input string tag, input int e, input bit en);
    int t;
    int idx;
    t = exp_tx.size();
    while (cyc < e + t + 8) @(posedge clk);
    #3;
    for (int k = 0; k < t + 4; k++) begin
      idx = (e + 1 + k) & 16'hFFFF;
      chk({tag, "_tx"}, tx_hist[idx], (k < t) ? exp_tx[k] : 1'b1);
      chk({tag, "_irq"}, irq_hist[idx], (en && k == t) ? 1'b1 : 1'b0);
      if (bv_hist[idx])
        chk({tag, "_busy"}, busy_hist[idx], (k < t) ? exp_busy[k] : 1'b0);
    end
  endtask

  task automatic run_frames(input string tag, input int d, input logic [7:0] bytes[$], input bit en);
    int e;
    wr(4'h3, 32'(en));
    wr(4'h2, 32'(d));
    for (int i = 0; i < bytes.size(); i++) begin
      wr(4'h0, {24'h0, bytes[i]});
      if (i == 0) e = e_last;
    end
    build_wave(d, bytes);
    check_window(tag, e, en);
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  q[$];
    int e, d, n;

    bus.ce = 1'b0; bus.rw = 1'b0; bus.address = 4'h1; bus.data_in = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    chk("rst_tx", bus.tx, 1'b1);
    chk("rst_irq", bus.irq, 1'b0);
    rd(4'h1, v); chk("rst_status", v, 32'h01);
    rd(4'h2, v); chk("rst_div", v, 32'd216);
    rd(4'h3, v); chk("rst_irq_en", v, 32'd0);
    rd(4'h0, v); chk("rst_txdata", v, 32'd0);
    rd(4'h9, v); chk("rst_unmapped", v, 32'd0);

    // Single frame, DIV=3, 0x55 (busy tracked each cycle)
    q = '{8'h55};
    run_frames("single", 3, q, 1'b0);
    rd(4'h2, v); chk("div_rb", v, 32'd3);

    // Interrupt: two back-to-back frames, one pulse after the last
    q = '{8'hA3, 8'h3C};
    run_frames("irq_on", 1, q, 1'b1);
    rd(4'h3, v); chk("irq_en_rb", v, 32'd1);
    q = '{8'hA3, 8'h3C};
    run_frames("irq_off", 1, q, 1'b0);

    // Randomized frames
    for (int it = 0; it < 5; it++) begin
      d = $urandom_range(0, 4);
      n = $urandom_range(1, 4);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      run_frames("rand", d, q, 1'($urandom_range(0, 1)));
    end

    // FIFO full / overflow: byte 0 pops at once, bytes 1..8 fill, byte 9 dropped
    wr(4'h3, 32'd0);
    wr(4'h2, 32'd100);
    for (int i = 0; i < 10; i++) begin
      wr(4'h0, 32'(i));
      if (i == 0) e = e_last;
    end
    rd(4'h1, v); chk("ovf_status", v, 32'h8E);
    wr(4'h1, 32'h0);
    rd(4'h1, v); chk("ovf_clear", v, 32'h86);
    q.delete();
    for (int i = 0; i < 9; i++) q.push_back(8'(i));
    build_wave(100, q);
    check_window("ovf", e, 1'b0);
    rd(4'h1, v); chk("ovf_drained", v, 32'h01);

    // Divisor change during the start bit
    wr(4'h2, 32'd7);
    wr(4'h0, 32'hFF);
    e = e_last;
    wr(4'h2, 32'd1);
    exp_tx.delete(); exp_busy.delete();
    for (int k = 0; k < 26; k++) begin
      exp_tx.push_back(k >= 8);
      exp_busy.push_back(1'b1);
    end
    check_window("divchg", e, 1'b0);

    // Reset mid-frame during data bit 4 with 3 bytes queued
    wr(4'h2, 32'd3);
    wr(4'h0, 32'h0F);
    e = e_last;
    wr(4'h0, 32'h22);
    wr(4'h0, 32'h33);
    wr(4'h0, 32'h44);
    rd(4'h1, v); chk("mid_queued", v, 32'h34);
    while (cyc < e + 21) @(negedge clk);
    chk("mid_bit4", tx_hist[(e + 21) & 16'hFFFF], 1'b0);
    rst = 1'b1;
    @(posedge clk); #2;
    chk("mid_rst_tx", bus.tx, 1'b1);
    @(negedge clk); rst = 1'b0;
    rd(4'h1, v); chk("mid_rst_status", v, 32'h01);
    rd(4'h2, v); chk("mid_rst_div", v, 32'd216);
    e = cyc;
    repeat (300) @(posedge clk);
    #3;
    for (int k = 0; k < 295; k++)
      chk("mid_quiet_tx", tx_hist[(e + 1 + k) & 16'hFFFF], 1'b1);
    rd(4'h1, v); chk("mid_final_status", v, 32'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
